// File: rtl/ic_solver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ic_solver_pkg
// Description : Shared types for the bit-vector shift solvers: comparison
//               predicate encoding and solver FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ic_solver_pkg;

    // Unsigned comparison predicate P(r, t) applied to the shifted operand
    typedef enum logic [1:0] {
        ULE = 2'd0,
        UGE = 2'd1,
        ULT = 2'd2,
        UGT = 2'd3
    } mode_e;

    // Solver control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Map an integer parameter value onto the predicate encoding
    function automatic mode_e to_mode(input int m);
        logic [1:0] v;
        v = m[1:0];
        return mode_e'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ic_bvashr_eval.sv
`default_nettype none
// ============================================================================
// Module      : ic_bvashr_eval
// Description : Combinational candidate evaluator. Arithmetically shifts s
//               right by x (x = W gives full sign fill) and applies the
//               unsigned predicate selected by MODE against t.
// Revision    : 1.0 - initial release
// ============================================================================
module ic_bvashr_eval
    import ic_solver_pkg::*;
#(
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int XW   = $clog2(W + 1)
) (
    input  logic [W-1:0]  s,
    input  logic [W-1:0]  t,
    input  logic [XW-1:0] x,
    output logic          pass
);

    localparam mode_e c_mode = to_mode(MODE);

    logic [W-1:0] w_shifted;

    // Sign-filling shift; shift amounts of W or more replicate the sign bit
    always_comb begin
        w_shifted = $signed(s) >>> x;
    end

    // Unsigned predicate on the shifted value
    always_comb begin
        pass = 1'b0;
        case (c_mode)
            ULE:     pass = (w_shifted <= t);
            UGE:     pass = (w_shifted >= t);
            ULT:     pass = (w_shifted <  t);
            UGT:     pass = (w_shifted >  t);
            default: pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ic_bvashr_solver.sv
`default_nettype none
// ============================================================================
// Module      : ic_bvashr_solver
// Description : Sequential solver returning the smallest shift amount x in
//               0..W for which P((s >>a x), t) holds. One candidate is
//               evaluated per cycle; one query in flight at a time.
//               Build option: IC_BVASHR_EARLY_EXIT_EN ends the search the
//               cycle after the first passing candidate instead of always
//               sweeping all W+1 candidates.
// Revision    : 1.0 - initial release
// ============================================================================
module ic_bvashr_solver
    import ic_solver_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int MODE = 0,
    localparam int XW   = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_s,
    input  logic [W-1:0]  in_t,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_found,
    output logic [XW-1:0] out_x
);

`ifdef IC_BVASHR_EARLY_EXIT_EN
    localparam logic c_early_exit = 1'b1;
`else
    localparam logic c_early_exit = 1'b0;
`endif

    localparam logic [XW-1:0] c_x_max = XW'(W);
    localparam logic [XW-1:0] c_x_one = XW'(1);

    state_e          r_state;
    state_e          w_state_next;
    logic [W-1:0]    r_s;
    logic [W-1:0]    r_t;
    logic [XW-1:0]   r_x;
    logic            r_last;
    logic            r_found;
    logic [XW-1:0]   r_xres;
    logic            w_pass;

    ic_bvashr_eval #(
        .W    (W),
        .MODE (MODE),
        .XW   (XW)
    ) u_eval (
        .s    (r_s),
        .t    (r_t),
        .x    (r_x),
        .pass (w_pass)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: leave SEARCH once the final candidate has been latched,
    // or once a witness is latched when early exit is built in
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = SEARCH;
            SEARCH:  if (r_last || (c_early_exit && r_found)) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, candidate counter and first-witness latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_t     <= '0;
            r_x     <= '0;
            r_last  <= 1'b0;
            r_found <= 1'b0;
            r_xres  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s     <= in_s;
                        r_t     <= in_t;
                        r_x     <= '0;
                        r_last  <= 1'b0;
                        r_found <= 1'b0;
                        r_xres  <= '0;
                    end
                end
                SEARCH: begin
                    // r_last freezes evaluation once x = W has been judged
                    if (!r_last) begin
                        if (w_pass && !r_found) begin
                            r_found <= 1'b1;
                            r_xres  <= r_x;
                        end
                        // Counter saturates at W rather than wrapping
                        if (r_x == c_x_max) begin
                            r_last <= 1'b1;
                        end else begin
                            r_x <= r_x + c_x_one;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and result outputs decoded from state and result registers
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        out_found = r_found;
        out_x     = r_xres;
    end

endmodule
`default_nettype wire
